// File: rtl/palm_run_locator.sv
// palm_run_locator
// Scans a raster-ordered binary (hand/background) pixel stream and reports the
// first horizontal run of hand pixels that is at least MIN_W wide.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   pix_valid         : pixel strobe; nothing advances without it
//   pix               : segmented pixel, 1 = hand
//   sof               : start of frame, marks the accepted pixel as (0,0)
//   test_mode         : select palm_height_test as the reported height
//   palm_height_test  : externally supplied height
//   start_r/start_c   : first pixel of the qualified run
//   end_r/end_c       : last pixel of the qualified run
//   palm_width/height : run width and derived (or test) height
//   done              : level, result for the current frame is held
//   no_palm           : one-cycle pulse, frame ended without a result
//   busy              : scanning a frame
module palm_run_locator #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int CW    = 8,
  parameter int MIN_W = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          pix,
  input  logic          sof,
  input  logic          test_mode,
  input  logic [CW-1:0] palm_height_test,
  output logic [CW-1:0] start_r,
  output logic [CW-1:0] start_c,
  output logic [CW-1:0] end_r,
  output logic [CW-1:0] end_c,
  output logic [CW-1:0] palm_width,
  output logic [CW-1:0] palm_height,
  output logic          done,
  output logic          no_palm,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_R = CW'(IMG_H - 1);
  localparam logic [CW:0]   MIN_WV = (CW + 1)'(MIN_W);

  logic [1:0]    r_state;
  logic [CW-1:0] r_row, r_col;
  logic          r_open;
  logic [CW-1:0] r_run_c;
  logic [CW-1:0] r_start_r, r_start_c, r_end_r, r_end_c, r_width, r_height;
  logic          r_no_palm;

  logic [1:0]    w_state;
  logic [CW-1:0] w_row, w_col;
  logic          w_last_col, w_frame_end;
  logic          w_open, w_close, w_qual;
  logic [CW-1:0] w_run_start, w_end_c;
  logic [CW:0]   w_width;
  logic [CW+1:0] w_hsum;
  logic [CW-1:0] w_height;

  // sof is folded in here so that the sof pixel is processed as (0,0) in SCAN
  // with an empty run tracker, whatever state the block was in.
  always_comb begin
    w_row       = sof ? '0 : r_row;
    w_col       = sof ? '0 : r_col;
    w_state     = sof ? SCAN : r_state;
    w_open      = sof ? 1'b0 : r_open;
    w_last_col  = (w_col == LAST_C);
    w_frame_end = w_last_col && (w_row == LAST_R);
    w_run_start = w_open ? r_run_c : w_col;
    // A hand pixel closes the run only at the row edge (and is part of it);
    // a background pixel closes an open run just before itself.
    w_close     = pix ? w_last_col : w_open;
    w_end_c     = pix ? w_col : (w_col - CW'(1));
    w_width     = {1'b0, w_end_c} - {1'b0, w_run_start} + (CW + 1)'(1);
    w_qual      = (w_state == SCAN) && w_close && (w_width >= MIN_WV);
    // floor(3w/2) == w + floor(w/2)
    w_hsum      = {1'b0, w_width} + {2'b00, w_width[CW:1]};
    w_height    = (|w_hsum[CW+1:CW]) ? '1 : w_hsum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_open    <= 1'b0;
      r_run_c   <= '0;
      r_start_r <= '0;
      r_start_c <= '0;
      r_end_r   <= '0;
      r_end_c   <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_no_palm <= 1'b0;
    end else begin
      r_no_palm <= 1'b0;
      if (pix_valid) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_frame_end ? '0 : (w_row + CW'(1));
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end

        if (w_state == SCAN) begin
          if (w_qual) begin
            r_start_r <= w_row;
            r_start_c <= w_run_start;
            r_end_r   <= w_row;
            r_end_c   <= w_end_c;
            r_width   <= w_width[CW-1:0];
            r_height  <= test_mode ? palm_height_test : w_height;
            r_open    <= 1'b0;
            r_state   <= DONE;
          end else if (w_frame_end) begin
            r_no_palm <= 1'b1;
            r_open    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_state <= SCAN;
            r_open  <= pix && !w_last_col;
            if (pix && !w_open) begin
              r_run_c <= w_col;
            end
          end
        end else begin
          r_state <= w_state;
        end
      end
    end
  end

  assign start_r     = r_start_r;
  assign start_c     = r_start_c;
  assign end_r       = r_end_r;
  assign end_c       = r_end_c;
  assign palm_width  = r_width;
  assign palm_height = r_height;
  assign done        = (r_state == DONE);
  assign no_palm     = r_no_palm;
  assign busy        = (r_state == SCAN);

endmodule

// File: tb/tb_palm_run_locator.sv
module tb_palm_run_locator;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int CWV  = 8;
  localparam int MINW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0;
  logic pix = 1'b0;
  logic sof = 1'b0;
  logic test_mode = 1'b0;
  logic [CWV-1:0] palm_height_test = '0;
  logic [CWV-1:0] start_r, start_c, end_r, end_c, palm_width, palm_height;
  logic done, no_palm, busy;

  typedef struct {
    bit palm;
    int due;
    int sr, sc, er, ec, w, h;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit img [H][W];

  palm_run_locator #(.IMG_W(W), .IMG_H(H), .CW(CWV), .MIN_W(MINW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix(pix), .sof(sof),
    .test_mode(test_mode), .palm_height_test(palm_height_test),
    .start_r(start_r), .start_c(start_c), .end_r(end_r), .end_c(end_c),
    .palm_width(palm_width), .palm_height(palm_height),
    .done(done), .no_palm(no_palm), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic void clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'b0;
  endfunction

  function automatic void hrun(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1 && c < W; c++) img[r][c] = 1'b1;
  endfunction

  // Reference: first run (in raster order) of width >= MINW in the image.
  // cidx is the index of the pixel whose acceptance decides the frame.
  function automatic void model(input bit tm, input int pht, output exp_t e, output int cidx);
    int c, s, en, w, h;
    e = '{default: 0};
    cidx = H * W - 1;
    for (int r = 0; r < H; r++) begin
      c = 0;
      while (c < W) begin
        if (img[r][c]) begin
          s = c;
          while (c < W && img[r][c]) c++;
          en = c - 1;
          w = en - s + 1;
          if (w >= MINW) begin
            h = (w * 3) / 2;
            if (h > 255) h = 255;
            e.palm = 1'b1;
            e.sr = r; e.sc = s; e.er = r; e.ec = en; e.w = w;
            e.h = tm ? pht : h;
            cidx = r * W + ((en == W - 1) ? en : en + 1);
            return;
          end
        end else begin
          c++;
        end
      end
    end
  endfunction

  // npix < 0: run until a little past the deciding pixel (or the full frame).
  task automatic send(input int npix, input int gap_pct, input bit tm, input int pht);
    exp_t e;
    int cidx, n;
    model(tm, pht, e, cidx);
    n = (npix < 0) ? (cidx + 21) : npix;
    if (n > H * W) n = H * W;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        pix_valid = 1'b0;
        sof = 1'($urandom_range(1));
        pix = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (i == 1) begin
        chk("done_low_after_sof", int'(done), 0);
        chk("busy_after_sof", int'(busy), 1);
      end
      pix_valid = 1'b1;
      sof = (i == 0);
      pix = img[i / W][i % W];
      test_mode = tm;
      palm_height_test = CWV'(pht);
      if (i == cidx) begin
        e.due = cyc + 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    sof = 1'b0;
    pix = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int sr, input int sc, input int er,
                            input int ec, input int w, input int h);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_start_r"}, int'(start_r), sr);
    chk({tag, "_start_c"}, int'(start_c), sc);
    chk({tag, "_end_r"}, int'(end_r), er);
    chk({tag, "_end_c"}, int'(end_c), ec);
    chk({tag, "_width"}, int'(palm_width), w);
    chk({tag, "_height"}, int'(palm_height), h);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start_r"}, int'(start_r), 0);
    chk({tag, "_start_c"}, int'(start_c), 0);
    chk({tag, "_end_r"}, int'(end_r), 0);
    chk({tag, "_end_c"}, int'(end_c), 0);
    chk({tag, "_width"}, int'(palm_width), 0);
    chk({tag, "_height"}, int'(palm_height), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_no_palm"}, int'(no_palm), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: pops an expectation whenever done rises or no_palm pulses.
  initial begin : monitor
    bit pd, pnp;
    exp_t e;
    pd = 1'b0;
    pnp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done && pd) begin
        chk("hold_start_r", int'(start_r), last_exp.sr);
        chk("hold_start_c", int'(start_c), last_exp.sc);
        chk("hold_end_c", int'(end_c), last_exp.ec);
        chk("hold_width", int'(palm_width), last_exp.w);
        chk("hold_height", int'(palm_height), last_exp.h);
      end
      if ((done && !pd) || no_palm) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: done=%0d no_palm=%0d at cycle %0d, none expected",
                   done, no_palm, cyc);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.due);
          chk("event_done", int'(done), int'(e.palm));
          chk("event_no_palm", int'(no_palm), int'(!e.palm));
          if (e.palm) begin
            chk("sb_start_r", int'(start_r), e.sr);
            chk("sb_start_c", int'(start_c), e.sc);
            chk("sb_end_r", int'(end_r), e.er);
            chk("sb_end_c", int'(end_c), e.ec);
            chk("sb_width", int'(palm_width), e.w);
            chk("sb_height", int'(palm_height), e.h);
            last_exp = e;
          end
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL event_timeout: nothing seen by cycle %0d, due at cycle %0d", cyc, e.due);
      end
      if (no_palm && pnp) begin
        n_cmp++;
        n_err++;
        $display("FAIL no_palm_pulse: high for 2+ cycles at cycle %0d, expected 1 cycle", cyc);
      end
      pd = done;
      pnp = no_palm;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int r, s, len;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // IDLE ignores pixels without sof
    clear_img();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix = 1'b1; sof = 1'b0;
    end
    @(negedge clk);
    pix_valid = 1'b0; pix = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    clear_img(); hrun(5, 40, 59);
    send(-1, 0, 1'b0, 0);
    chk_result("basic", 5, 40, 5, 59, 20, 30);
    send(-1, 30, 1'b0, 0);
    chk_result("gaps", 5, 40, 5, 59, 20, 30);

    clear_img(); hrun(2, 10, 20); hrun(3, 0, 24);
    send(-1, 0, 1'b0, 0);
    chk_result("narrow_first", 3, 0, 3, 24, 25, 37);

    clear_img(); hrun(7, 140, 159);
    send(-1, 0, 1'b1, 99);
    chk_result("row_edge", 7, 140, 7, 159, 20, 99);

    // later hand rows after a result must leave outputs frozen
    clear_img(); hrun(4, 30, 59);
    for (int rr = 8; rr <= 20; rr++) hrun(rr, 0, W - 1);
    send(25 * W, 0, 1'b0, 0);
    chk_result("frozen", 4, 30, 4, 59, 30, 45);

    for (int k = 0; k < 8; k++) begin
      clear_img();
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        r = int'($urandom_range(0, 14));
        s = int'($urandom_range(0, W - 1));
        len = int'($urandom_range(1, MINW + 10));
        hrun(r, s, s + len - 1);
      end
      s = int'($urandom_range(0, W - MINW));
      len = int'($urandom_range(MINW, W - s));
      hrun(15, s, s + len - 1);
      send(-1, (k == 0) ? 20 : 0, 1'($urandom_range(1)), int'($urandom_range(0, 255)));
    end

    // all-background frame
    clear_img();
    send(-1, 0, 1'b0, 0);
    chk("nopalm_busy", int'(busy), 0);
    chk("nopalm_done", int'(done), 0);
    @(negedge clk);
    chk("nopalm_after", int'(no_palm), 0);

    // qualifying run closed by the very last pixel of the frame
    clear_img(); hrun(10, 0, 9); hrun(50, 3, 12); hrun(119, 100, 116); hrun(119, 140, 159);
    send(-1, 0, 1'b0, 0);
    chk_result("last_pixel", 119, 140, 119, 159, 20, 30);

    // reset in the middle of a run
    clear_img(); hrun(5, 40, 59);
    send(5 * W + 45, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b1; sof = 1'b1; pix = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0; sof = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix = 1'b1; sof = 1'b0;
    end
    @(negedge clk);
    pix_valid = 1'b0; pix = 1'b0;
    chk("post_reset_done", int'(done), 0);
    chk("post_reset_busy", int'(busy), 0);

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending_events: %0d still queued, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/palm_run_locator.md
PALM_RUN_LOCATOR -- requirements
Module: palm_run_locator

Interface
REQ-001 Parameter IMG_W, default 160, pixels per image row.
REQ-002 Parameter IMG_H, default 120, rows per frame.
REQ-003 Parameter CW, default 8, width of all coordinate, width and height outputs; IMG_W-1 and IMG_H-1 shall fit in CW bits.
REQ-004 Parameter MIN_W, default 18, minimum run width in pixels that qualifies as a palm.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pix_valid  in  1  pixel strobe; a pixel is accepted only on cycles where pix_valid=1.
REQ-008 pix  in  1  segmented pixel; 1 = hand, 0 = background.
REQ-009 sof  in  1  start of frame; qualified by pix_valid; marks the accepted pixel as (row 0, col 0).
REQ-010 test_mode  in  1  when 1, palm_height is taken from palm_height_test.
REQ-011 palm_height_test  in  CW  externally supplied palm height.
REQ-012 start_r, start_c  out  CW each  row and column of the first pixel of the qualified run.
REQ-013 end_r, end_c  out  CW each  row and column of the last pixel of the qualified run.
REQ-014 palm_width, palm_height  out  CW each  width and height of the qualified run.
REQ-015 done  out  1  level; high while outputs hold a qualified result for the current frame.
REQ-016 no_palm  out  1  one-cycle pulse; the frame ended without a qualified run.
REQ-017 busy  out  1  high in state SCAN.

Function
REQ-018 The FSM shall have states IDLE, SCAN and DONE; after reset it is in IDLE.
REQ-019 IDLE: accepted pixels without sof are ignored; an accepted pixel with sof enters SCAN and that pixel is processed as (0,0).
REQ-020 col/row counters advance only on accepted pixels: col increments; at col=IMG_W-1 col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) the frame ends.
REQ-021 sof in any state restarts the frame: counters reset to (0,0), the run tracker clears, done drops, the state becomes SCAN and the pixel is processed at (0,0).
REQ-022 SCAN run tracking: a hand pixel with no open run opens a run at the current (row,col); further hand pixels extend it.
REQ-023 A run closes on the first background pixel, or on a hand pixel at col=IMG_W-1; a closing hand pixel is included in the run, and runs never span rows.
REQ-024 Run width = end_c - start_c + 1, computed in CW+1 bits; a single hand pixel has width 1.
REQ-025 A closed run with width >= MIN_W qualifies; non-qualifying runs are discarded and leave the outputs unchanged.
REQ-026 On qualification, in the same edge, the block latches start_r/c, end_r/c and palm_width, sets done=1 and enters DONE; all outputs are valid the cycle after the closing pixel is accepted.
REQ-027 palm_height = palm_height_test if test_mode=1, else floor(width*3/2) saturated to 2^CW-1; test_mode is sampled at the qualifying pixel.
REQ-028 DONE: outputs are frozen and pixels without sof are ignored (counters still run); only sof or rst leaves DONE.
REQ-029 Frame end in SCAN without a qualified run: no_palm pulses for one cycle, the state becomes IDLE and outputs are unchanged.
REQ-030 If the final pixel of a frame closes a qualifying run, qualification takes priority and no_palm is not asserted.
REQ-031 pix_valid=0 cycles hold all state, counters and run tracking unchanged.

Reset
REQ-032 rst=1 forces state IDLE, counters 0, open run cleared, and all CW-bit outputs, done, no_palm and busy to 0.
REQ-033 rst overrides sof and pix_valid in the same cycle, and reset in the middle of a frame discards the partial run.

Verification
REQ-034 Defaults; sof, then row 5 with hand at cols 40..59 and all other pixels background -> done=1 one cycle after col 60 is accepted; start=(5,40), end=(5,59), width=20, height=30.
REQ-035 Row 2 hand at cols 10..20 (width 11), row 3 hand at cols 0..24 -> the row-2 run is ignored; result start=(3,0), end=(3,24), width=25, height=37.
REQ-036 Row 7 hand at cols 140..159 -> the run closes at the row edge; end=(7,159), width=20; test_mode=1 with palm_height_test=99 gives height=99.
REQ-037 A full frame of background -> no_palm pulses exactly once after pixel (119,159), the state returns to IDLE and done stays 0.
REQ-038 A qualifying run, then hand pixels in later rows -> outputs unchanged; the next sof clears done and a new result replaces the old one.
REQ-039 rst asserted at pixel (5,45) of a run starting at col 40 -> all outputs are 0, and pixels without sof produce no result; pix_valid gaps inserted in REQ-034 give the identical result.
